wb_ibus_prefetch: RTL and testbench

Sequential instruction prefetch buffer between the processor's instruction Wishbone port and the SoC interconnect's `ibus` master port. It serves core fetches from a small FIFO of consecutive words. While the FIFO has room, it fetches ahead at +4 byte strides. Any non-sequential fetch (branch, trap, `flush_i`) discards the buffered stream and restarts fetching at the new address.

---
 rtl/wb_prefetch_pkg.sv | 19 +
 rtl/prefetch_fifo.sv | 58 +++++
 rtl/wb_ibus_prefetch.sv | 150 +++++++++++++++
 tb/tb_wb_ibus_prefetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_prefetch_pkg.sv
// Shared definitions for the instruction-bus prefetch buffer.
//   fsm_state_e : master-side FSM encoding (idle, fetch in progress, draining a stale fetch)
//   WORD_BYTES  : byte stride between consecutive instruction words
//   is_pow2()   : elaboration-time check used on the FIFO depth
package wb_prefetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } fsm_state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding prefetched instruction words.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   clear_ni  : synchronous active-low clear (discards all entries)
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : word to write
//   pop_i     : advance the read pointer (ignored when empty)
//   rdata_o   : word at the head, valid while count_o != 0
//   count_o   : number of stored entries, 0..DEPTH
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_ni,
    input  logic                       push_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i & (count_q != FullCnt);
    assign do_pop  = pop_i & (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !clear_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_ibus_prefetch.sv
// Sequential instruction prefetch buffer between the core's instruction Wishbone port
// (s_wb_*) and the interconnect's ibus master port (m_wb_*). Core fetches are served from
// a FIFO of consecutive words; while the FIFO has room the next word is fetched ahead.
// A non-sequential fetch or flush_i drops the buffered stream and restarts at the new address.
//   wb_clk, wb_rst_n   : clock, synchronous active-low reset
//   flush_i            : one-cycle invalidate (fence.i)
//   s_wb_adr/cyc/stb   : core fetch request
//   s_wb_rdt/ack       : instruction word and one-cycle acknowledge
//   m_wb_adr/cyc/stb   : classic-cycle fetch to interconnect, held until m_wb_ack
//   m_wb_rdt/ack       : interconnect read data and acknowledge
module wb_ibus_prefetch
    import wb_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          flush_i,
    input  logic [AW-1:0] s_wb_adr,
    input  logic          s_wb_cyc,
    input  logic          s_wb_stb,
    output logic [31:0]   s_wb_rdt,
    output logic          s_wb_ack,
    output logic [AW-1:0] m_wb_adr,
    output logic          m_wb_cyc,
    output logic          m_wb_stb,
    input  logic [31:0]   m_wb_rdt,
    input  logic          m_wb_ack
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("wb_ibus_prefetch: DEPTH must be a power of two and at least 2");
    end

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [AW-1:0] Stride  = AW'(WORD_BYTES);

    fsm_state_e    state_q, state_d;
    logic [AW-1:0] head_adr_q, head_adr_d;
    logic [AW-1:0] fetch_adr_q, fetch_adr_d;
    logic          stream_valid_q, stream_valid_d;
    logic          s_ack_q, s_ack_d;
    logic [31:0]   s_rdt_q, s_rdt_d;
    logic          m_cyc_q, m_cyc_d;
    logic [AW-1:0] m_adr_q, m_adr_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [31:0]   fifo_rdata;
    logic          pending;
    logic          hit;
    logic          wait_fetch;
    logic          miss;
    logic          restart;
    logic          push;
    logic          pop;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) u_fifo (
        .clk_i    (wb_clk),
        .rst_ni   (wb_rst_n),
        .clear_ni (~restart),
        .push_i   (push),
        .wdata_i  (m_wb_rdt),
        .pop_i    (pop),
        .rdata_o  (fifo_rdata),
        .count_o  (fifo_count)
    );

    always_comb begin
        // The ack cycle masks the request so a held request is never acked twice in a row.
        pending = s_wb_cyc & s_wb_stb & ~s_ack_q;
        hit     = pending & ~flush_i & (fifo_count != '0) & (s_wb_adr == head_adr_q);
        // Empty buffer but the wanted word is the one being (or about to be) fetched: wait.
        wait_fetch = ~flush_i & (fifo_count == '0) & stream_valid_q & (s_wb_adr == fetch_adr_q);
        miss    = pending & ~hit & ~wait_fetch;
        restart = miss | flush_i;
        push    = (state_q == StFetch) & m_wb_ack & ~restart;
        pop     = hit;

        count_next = restart ? '0 : fifo_count + CW'(push) - CW'(pop);

        head_adr_d     = head_adr_q;
        fetch_adr_d    = fetch_adr_q;
        stream_valid_d = stream_valid_q;
        if (hit)     head_adr_d = head_adr_q + Stride;
        if (push)    fetch_adr_d = fetch_adr_q + Stride;
        if (flush_i) stream_valid_d = 1'b0;
        if (miss) begin
            head_adr_d     = s_wb_adr;
            fetch_adr_d    = s_wb_adr;
            stream_valid_d = 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (stream_valid_d && (count_next < FullCnt)) state_d = StFetch;
            end
            StFetch: begin
                // An ack always ends the cycle; its data is kept only if the stream survived.
                if (m_wb_ack)     state_d = StIdle;
                else if (restart) state_d = StDrain;
            end
            StDrain: begin
                if (m_wb_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        s_ack_d = hit;
        s_rdt_d = hit ? fifo_rdata : s_rdt_q;
        m_cyc_d = (state_d != StIdle);
        // The address only changes when a new master cycle starts; a drain keeps the stale one.
        m_adr_d = ((state_q == StIdle) && (state_d == StFetch)) ? fetch_adr_d : m_adr_q;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q        <= StIdle;
            head_adr_q     <= '0;
            fetch_adr_q    <= '0;
            stream_valid_q <= 1'b0;
            s_ack_q        <= 1'b0;
            s_rdt_q        <= '0;
            m_cyc_q        <= 1'b0;
            m_adr_q        <= '0;
        end else begin
            state_q        <= state_d;
            head_adr_q     <= head_adr_d;
            fetch_adr_q    <= fetch_adr_d;
            stream_valid_q <= stream_valid_d;
            s_ack_q        <= s_ack_d;
            s_rdt_q        <= s_rdt_d;
            m_cyc_q        <= m_cyc_d;
            m_adr_q        <= m_adr_d;
        end
    end

    assign s_wb_ack = s_ack_q;
    assign s_wb_rdt = s_rdt_q;
    assign m_wb_cyc = m_cyc_q;
    assign m_wb_stb = m_cyc_q;
    assign m_wb_adr = m_adr_q;

endmodule

// File: tb/tb_wb_ibus_prefetch.sv
// Self-checking bench for wb_ibus_prefetch: an interconnect model with programmable ack
// latency answers fetches with rom(adr) = adr ^ DEADBEEF, and a core driver issues fetches.
module tb_wb_ibus_prefetch;

    logic        clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] s_wb_adr = '0;
    logic        s_wb_cyc = 1'b0;
    logic        s_wb_stb = 1'b0;
    logic [31:0] s_wb_rdt;
    logic        s_wb_ack;
    logic [31:0] m_wb_adr;
    logic        m_wb_cyc;
    logic        m_wb_stb;
    logic [31:0] m_wb_rdt;
    logic        m_wb_ack;

    // Interconnect model state.
    logic        resp_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdt = '0;
    logic        man_ack = 1'b0;
    int          lat_cfg = 1;
    int          wait_cnt = 0;
    logic [31:0] fetch_log[$];

    int n_checks = 0;
    int n_err = 0;

    assign m_wb_ack = resp_en ? resp_ack : man_ack;
    assign m_wb_rdt = resp_en ? resp_rdt : 32'hBAD0_BAD0;

    wb_ibus_prefetch #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .wb_clk   (clk),
        .wb_rst_n (wb_rst_n),
        .flush_i  (flush_i),
        .s_wb_adr (s_wb_adr),
        .s_wb_cyc (s_wb_cyc),
        .s_wb_stb (s_wb_stb),
        .s_wb_rdt (s_wb_rdt),
        .s_wb_ack (s_wb_ack),
        .m_wb_adr (m_wb_adr),
        .m_wb_cyc (m_wb_cyc),
        .m_wb_stb (m_wb_stb),
        .m_wb_rdt (m_wb_rdt),
        .m_wb_ack (m_wb_ack)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Acks the held cycle after lat_cfg cycles of stb; decisions made on the falling edge.
    always @(negedge clk) begin
        if (resp_en) begin
            if (m_wb_cyc && m_wb_stb && !resp_ack) begin
                if (wait_cnt + 1 >= lat_cfg) begin
                    resp_ack = 1'b1;
                    resp_rdt = rom(m_wb_adr);
                    fetch_log.push_back(m_wb_adr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                resp_ack = 1'b0;
                wait_cnt = 0;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One core fetch: request on a falling edge, wait (bounded) for ack, then release.
    task automatic core_fetch(input logic [31:0] adr, output logic [31:0] rdt, output int lat);
        @(negedge clk);
        s_wb_adr = adr;
        s_wb_cyc = 1'b1;
        s_wb_stb = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_wb_ack && lat < 60);
        rdt = s_wb_rdt;
        if (!s_wb_ack) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_timeout: adr %h got no ack within %0d cycles", adr, lat);
        end
        s_wb_cyc = 1'b0;
        s_wb_stb = 1'b0;
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] rdt;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] rdt;
    } wvec_t;

    vec_t        vecs[15];
    wvec_t       wvecs[4];
    logic [31:0] rdt;
    int          lat;
    int          base;
    int          bad;
    int          cyc_high;

    initial begin
        // Stream from a full FIFO at L=1: every fetch is a hit, acked one cycle later.
        vecs[0]  = '{32'h04, 32'hDEADBEEB, 1};
        vecs[1]  = '{32'h08, 32'hDEADBEE7, 1};
        vecs[2]  = '{32'h0C, 32'hDEADBEE3, 1};
        vecs[3]  = '{32'h10, 32'hDEADBEFF, 1};
        vecs[4]  = '{32'h14, 32'hDEADBEFB, 1};
        vecs[5]  = '{32'h18, 32'hDEADBEF7, 1};
        vecs[6]  = '{32'h1C, 32'hDEADBEF3, 1};
        vecs[7]  = '{32'h20, 32'hDEADBECF, 1};
        vecs[8]  = '{32'h24, 32'hDEADBECB, 1};
        vecs[9]  = '{32'h28, 32'hDEADBEC7, 1};
        vecs[10] = '{32'h2C, 32'hDEADBEC3, 1};
        vecs[11] = '{32'h30, 32'hDEADBEDF, 1};
        vecs[12] = '{32'h34, 32'hDEADBEDB, 1};
        vecs[13] = '{32'h38, 32'hDEADBED7, 1};
        vecs[14] = '{32'h3C, 32'hDEADBED3, 1};
        wvecs[0] = '{32'hFFFF_FFF8, 32'h2152_4117};
        wvecs[1] = '{32'hFFFF_FFFC, 32'h2152_4113};
        wvecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF};
        wvecs[3] = '{32'h0000_0004, 32'hDEAD_BEEB};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ack", 32'(s_wb_ack), 32'd0);
        check("rst_s_rdt", s_wb_rdt, 32'd0);
        check("rst_m_cyc", 32'(m_wb_cyc), 32'd0);
        check("rst_m_stb", 32'(m_wb_stb), 32'd0);
        check("rst_m_adr", m_wb_adr, 32'd0);
        wb_rst_n = 1'b1;

        // Cold miss at L=1: ack at L+2, then the FIFO fills 4..16 and stops.
        lat_cfg = 1;
        core_fetch(32'h0, rdt, lat);
        check("cold_rdt", rdt, 32'hDEAD_BEEF);
        check("cold_lat", 32'(lat), 32'd3);
        repeat (20) @(negedge clk);
        check("fill_log_size", 32'(fetch_log.size()), 32'd5);
        bad = 0;
        for (int i = 0; i < fetch_log.size(); i++) if (fetch_log[i] != 32'(4 * i)) bad++;
        check("fill_log_seq", 32'(bad), 32'd0);
        check("fill_count", 32'(dut.u_fifo.count_o), 32'd4);
        check("fill_cyc_low", 32'(m_wb_cyc), 32'd0);

        // Table-driven sequential stream.
        for (int i = 0; i < 15; i++) begin
            core_fetch(vecs[i].adr, rdt, lat);
            check($sformatf("stream_rdt_%h", vecs[i].adr), rdt, vecs[i].rdt);
            check($sformatf("stream_lat_%h", vecs[i].adr), 32'(lat), 32'(vecs[i].lat));
        end
        repeat (12) @(negedge clk);
        check("stream_log_size", 32'(fetch_log.size()), 32'd20);
        bad = 0;
        for (int i = 0; i < fetch_log.size(); i++) if (fetch_log[i] != 32'(4 * i)) bad++;
        check("stream_log_seq", 32'(bad), 32'd0);

        // Branch during an in-flight fetch with L=3: the stale word is drained and discarded.
        lat_cfg = 3;
        base = fetch_log.size();
        core_fetch(32'h0, rdt, lat);
        check("br_miss_rdt", rdt, 32'hDEAD_BEEF);
        check("br_miss_lat", 32'(lat), 32'd5);
        core_fetch(32'h100, rdt, lat);
        check("br_rdt", rdt, 32'hDEAD_BFEF);
        check("br_lat", 32'(lat), 32'd7);
        check("br_log0", fetch_log[base], 32'h0);
        check("br_log1", fetch_log[base + 1], 32'h4);
        check("br_log2", fetch_log[base + 2], 32'h100);
        core_fetch(32'h104, rdt, lat);
        check("br_next_rdt", rdt, 32'hDEAD_BFEB);

        // Flush with a full FIFO: no fetching until the next request, which refetches.
        lat_cfg = 1;
        repeat (30) @(negedge clk);
        check("pre_flush_count", 32'(dut.u_fifo.count_o), 32'd4);
        base = fetch_log.size();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        cyc_high = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_wb_cyc) cyc_high++;
        end
        check("flush_count", 32'(dut.u_fifo.count_o), 32'd0);
        check("flush_cyc_low", 32'(cyc_high), 32'd0);
        check("flush_no_fetch", 32'(fetch_log.size()), 32'(base));
        core_fetch(32'h20, rdt, lat);
        check("flush_re_rdt", rdt, 32'hDEAD_BECF);
        check("flush_re_lat", 32'(lat), 32'd3);
        check("flush_re_log", fetch_log[base], 32'h20);

        // Address wrap past FFFF_FFFC.
        repeat (20) @(negedge clk);
        base = fetch_log.size();
        for (int i = 0; i < 4; i++) begin
            core_fetch(wvecs[i].adr, rdt, lat);
            check($sformatf("wrap_rdt_%h", wvecs[i].adr), rdt, wvecs[i].rdt);
            if (i == 0) check("wrap_lat", 32'(lat), 32'd3);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_log_%0d", i), fetch_log[base + i], wvecs[i].adr);
        end

        // Reset during FETCH, then a late interconnect ack.
        repeat (20) @(negedge clk);
        resp_en = 1'b0;
        man_ack = 1'b0;
        @(negedge clk);
        s_wb_adr = 32'h200;
        s_wb_cyc = 1'b1;
        s_wb_stb = 1'b1;
        @(negedge clk);
        check("rf_cyc_up", 32'(m_wb_cyc), 32'd1);
        check("rf_adr", m_wb_adr, 32'h200);
        s_wb_cyc = 1'b0;
        s_wb_stb = 1'b0;
        wb_rst_n = 1'b0;
        @(negedge clk);
        check("rf_s_ack", 32'(s_wb_ack), 32'd0);
        check("rf_s_rdt", s_wb_rdt, 32'd0);
        check("rf_m_cyc", 32'(m_wb_cyc), 32'd0);
        check("rf_m_stb", 32'(m_wb_stb), 32'd0);
        check("rf_m_adr", m_wb_adr, 32'd0);
        wb_rst_n = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("rf_late_count", 32'(dut.u_fifo.count_o), 32'd0);
        check("rf_late_cyc", 32'(m_wb_cyc), 32'd0);
        check("rf_late_s_ack", 32'(s_wb_ack), 32'd0);
        @(negedge clk);
        check("rf_late_cyc2", 32'(m_wb_cyc), 32'd0);
        resp_en = 1'b1;
        core_fetch(32'h300, rdt, lat);
        check("rf_after_rdt", rdt, 32'hDEAD_BDEF);
        check("rf_after_lat", 32'(lat), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
